// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory handshake, redirect draining and stall buffering.
// Optional build macro FETCH_ALIGN_CHECK_EN adds word-aligning of redirect targets and a fetch_misalign pulse.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        branch_in,
  input  logic [31:0] branch_target,
  input  logic        jump_in,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pcplus4_out,
  output logic        fetch_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_r;

  logic        redirect_s;
  logic [31:0] raw_target_s;
  logic [31:0] target_s;
  logic [31:0] pc_next4_s;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_s;
`endif

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect selection: jump wins over branch when both are requested.
  always_comb begin
    redirect_s = jump_in | branch_in;
    if (jump_in) begin
      raw_target_s = jump_target;
    end else begin
      raw_target_s = branch_target;
    end
    pc_next4_s = pc_r + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_s = redirect_s && (raw_target_s[1:0] != 2'b00);
    target_s   = align_word(raw_target_s);
`else
    target_s   = raw_target_s;
`endif
  end

  // Fetch FSM with all outputs registered; in DRAIN imem_addr keeps the killed address while pc_r holds the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      buf_r       <= 32'h0000_0000;
      imem_req    <= 1'b1;
      imem_addr   <= RESET_PC;
      instr_out   <= 32'h0000_0000;
      pcplus4_out <= 32'h0000_0000;
      fetch_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= misalign_s;
`endif
      case (state_r)
        FETCH: begin
          if (redirect_s) begin
            pc_r        <= target_s;
            buf_r       <= 32'h0000_0000;
            fetch_valid <= 1'b0;
            if (imem_ready) begin
              imem_addr <= target_s;
            end else begin
              state_r <= DRAIN;
            end
          end else if (imem_ready && !stallF) begin
            instr_out   <= imem_rdata;
            pcplus4_out <= pc_next4_s;
            fetch_valid <= 1'b1;
            pc_r        <= pc_next4_s;
            imem_addr   <= pc_next4_s;
          end else if (imem_ready) begin
            buf_r    <= imem_rdata;
            imem_req <= 1'b0;
            state_r  <= HOLD;
          end else if (!stallF) begin
            fetch_valid <= 1'b0;
          end else begin
            fetch_valid <= fetch_valid;
          end
        end

        DRAIN: begin
          if (redirect_s) begin
            pc_r        <= target_s;
            fetch_valid <= 1'b0;
          end else if (imem_ready) begin
            imem_addr <= pc_r;
            state_r   <= FETCH;
            if (!stallF) begin
              fetch_valid <= 1'b0;
            end else begin
              fetch_valid <= fetch_valid;
            end
          end else if (!stallF) begin
            fetch_valid <= 1'b0;
          end else begin
            fetch_valid <= fetch_valid;
          end
        end

        HOLD: begin
          if (redirect_s) begin
            pc_r        <= target_s;
            imem_addr   <= target_s;
            imem_req    <= 1'b1;
            buf_r       <= 32'h0000_0000;
            fetch_valid <= 1'b0;
            state_r     <= FETCH;
          end else if (!stallF) begin
            instr_out   <= buf_r;
            pcplus4_out <= pc_next4_s;
            fetch_valid <= 1'b1;
            pc_r        <= pc_next4_s;
            imem_addr   <= pc_next4_s;
            imem_req    <= 1'b1;
            buf_r       <= 32'h0000_0000;
            state_r     <= FETCH;
          end else begin
            buf_r <= buf_r;
          end
        end

        default: begin
          state_r     <= FETCH;
          imem_req    <= 1'b1;
          imem_addr   <= pc_r;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, and random traffic vs. a reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        branch_in;
  logic [31:0] branch_target;
  logic        jump_in;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pcplus4_out;
  logic        fetch_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stallF        (stallF),
    .branch_in     (branch_in),
    .branch_target (branch_target),
    .jump_in       (jump_in),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pcplus4_out   (pcplus4_out),
    .fetch_valid   (fetch_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic stall, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [31:0] jt, input logic rdy, input logic [31:0] rd,
                         input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                         input logic [31:0] e_p4, input logic e_valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.rdy = rdy; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_p4 = e_p4; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic rdy, input logic [31:0] rd);
    reset = rst; stallF = stall; branch_in = br; branch_target = bt;
    jump_in = jmp; jump_target = jt; imem_ready = rdy; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the fetch stage described as "pc", an optional buffered word, and a drain flag.
  logic [31:0] m_pc, m_killed, m_instr, m_p4;
  logic [31:0] m_buf[$];
  logic        m_drain, m_valid, m_mis;

  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir;
    redir = jump_in || branch_in;
    tgt   = jump_in ? jump_target : branch_target;
    m_mis = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    m_mis = redir && (tgt % 32'd4 != 32'd0);
    tgt   = tgt - (tgt % 32'd4);
`endif
    if (reset) begin
      m_pc = 32'h0; m_drain = 1'b0; m_buf.delete();
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (redir) begin
        m_buf.delete(); m_pc = tgt; m_valid = 1'b0;
      end else if (!stallF) begin
        m_instr = m_buf.pop_front(); m_pc = m_pc + 32'd4; m_p4 = m_pc; m_valid = 1'b1;
      end
    end else if (m_drain) begin
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0;
      end else begin
        if (imem_ready) m_drain = 1'b0;
        if (!stallF) m_valid = 1'b0;
      end
    end else begin
      if (redir) begin
        if (!imem_ready) begin
          m_drain = 1'b1; m_killed = m_pc;
        end
        m_pc = tgt; m_valid = 1'b0;
      end else if (imem_ready && !stallF) begin
        m_instr = imem_rdata; m_pc = m_pc + 32'd4; m_p4 = m_pc; m_valid = 1'b1;
      end else if (imem_ready) begin
        m_buf.push_back(imem_rdata);
      end else if (!stallF) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    check("rnd_req", {31'd0, imem_req}, {31'd0, m_buf.size() == 0});
    check("rnd_addr", imem_addr, m_drain ? m_killed : m_pc);
    check("rnd_instr", instr_out, m_instr);
    check("rnd_pcplus4", pcplus4_out, m_p4);
    check("rnd_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
`ifdef FETCH_ALIGN_CHECK_EN
    check("rnd_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
`endif
  endtask

  initial begin
    logic [31:0] rt;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    //      rst   stall br    bt          jmp   jt            rdy   rdata         req   addr          instr         pc+4          valid
    add_vec(1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hA0A0_0000, 1'b1, 32'h4,       32'hA0A0_0000, 32'h4,       1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hA1A1_0004, 1'b1, 32'h8,       32'hA1A1_0004, 32'h8,       1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h1111_1111, 1'b1, 32'h8,       32'hA1A1_0004, 32'h8,       1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h2222_2222, 1'b1, 32'h8,       32'hA1A1_0004, 32'h8,       1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h3333_3333, 1'b1, 32'h8,       32'hA1A1_0004, 32'h8,       1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hA2A2_0008, 1'b1, 32'hC,       32'hA2A2_0008, 32'hC,       1'b1);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 32'hC,       32'hA2A2_0008, 32'hC,       1'b1);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h4444_4444, 1'b0, 32'hC,       32'hA2A2_0008, 32'hC,       1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h5555_5555, 1'b1, 32'h10,      32'hDEAD_BEEF, 32'h10,      1'b1);
    add_vec(1'b0, 1'b0, 1'b1, 32'h80,     1'b1, 32'h100,      1'b1, 32'h6666_6666, 1'b1, 32'h100,     32'hDEAD_BEEF, 32'h10,      1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hB0B0_0100, 1'b1, 32'h104,     32'hB0B0_0100, 32'h104,     1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h200,      1'b0, 32'h7777_7777, 1'b1, 32'h104,     32'hB0B0_0100, 32'h104,     1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h8888_8888, 1'b1, 32'h104,     32'hB0B0_0100, 32'h104,     1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hBAD0_BAD0, 1'b1, 32'h200,     32'hB0B0_0100, 32'h104,     1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hC0C0_0200, 1'b1, 32'h204,     32'hC0C0_0200, 32'h204,     1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'hFFFF_FFFC, 1'b1, 32'h9999_9999, 1'b1, 32'hFFFF_FFFC, 32'hC0C0_0200, 32'h204,  1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hC1C1_FFFC, 1'b1, 32'h0,       32'hC1C1_FFFC, 32'h0,       1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h300,      1'b0, 32'hAAAA_AAAA, 1'b1, 32'h0,       32'hC1C1_FFFC, 32'h0,       1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hBBBB_BBBB, 1'b1, 32'h0,       32'h0,        32'h0,        1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hD0D0_0000, 1'b1, 32'h4,       32'hD0D0_0000, 32'h4,       1'b1);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hE0E0_0004, 1'b0, 32'h4,       32'hD0D0_0000, 32'h4,       1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 32'h40,     1'b0, 32'h0,        1'b0, 32'hCCCC_CCCC, 1'b1, 32'h40,      32'hD0D0_0000, 32'h4,       1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 32'hE1E1_0040, 1'b1, 32'h44,      32'hE1E1_0040, 32'h44,      1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].rdy, vecs[i].rd);
      tick();
      check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_instr", i), instr_out, vecs[i].e_instr);
      check($sformatf("vec%0d_pcplus4", i), pcplus4_out, vecs[i].e_p4);
      check($sformatf("vec%0d_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_valid});
    end

    // Misaligned jump target from PC=0x44, then one normal fetch.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b1, 32'h1234_5678);
    tick();
    check("misjmp_valid", {31'd0, fetch_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misjmp_addr", imem_addr, 32'h200);
    check("misjmp_pulse", {31'd0, fetch_misalign}, 32'd1);
`else
    check("misjmp_addr", imem_addr, 32'h203);
`endif
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hF0F0_0200);
    tick();
    check("misjmp_instr", instr_out, 32'hF0F0_0200);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misjmp_next_addr", imem_addr, 32'h204);
    check("misjmp_pcplus4", pcplus4_out, 32'h204);
    check("misjmp_pulse_end", {31'd0, fetch_misalign}, 32'd0);
`else
    check("misjmp_next_addr", imem_addr, 32'h207);
    check("misjmp_pcplus4", pcplus4_out, 32'h207);
`endif

    // Random traffic against the reference model, starting from a reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_edge();
    tick();
    model_check();
    for (int n = 0; n < 3000; n++) begin
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt = rt & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), rt,
            ($urandom_range(0, 9) == 0), rt ^ 32'h0000_0F00,
            ($urandom_range(0, 1) == 1), $urandom);
      model_edge();
      tick();
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
